// File: rtl/vex_uop_sink.sv
`default_nettype none
// ============================================================================
//  Module   : vex_uop_sink
//  Purpose  : Execute-side endpoint of the vector issue->execute handshake.
//             Accepts lane uops (valid/ready), runs a 2-stage lane ALU
//             (add/sub/logic, multi-cycle vmul, reductions), drives per-lane
//             writebacks to the VRF element write port and flags reduction
//             completion.
//  Ports    : clk_i/rst_i        clock, synchronous active-high reset
//             valid_i/ready_o    uop handshake
//             lane_valid_i, data1_i, data2_i, mask_i, funct6_i, funct3_i,
//             dst_i, head_uop_i, end_uop_i, is_rdc_i   uop payload
//             wr_en_o/wr_addr_o/wr_data_o              VRF writeback
//             rdc_done_o                               reduction result valid
//             busy_o                                   work in flight
//  Revision : 1.0  initial release
// ============================================================================
module vex_uop_sink #(
    parameter int VECTOR_LANES    = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int VREG_ADDR_WIDTH = 5,
    parameter int MUL_CYCLES      = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [VECTOR_LANES-1:0]              lane_valid_i,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   data1_i,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   data2_i,
    input  logic [VECTOR_LANES-1:0]              mask_i,
    input  logic [5:0]                           funct6_i,
    input  logic [2:0]                           funct3_i,
    input  logic [VREG_ADDR_WIDTH-1:0]           dst_i,
    input  logic                                 head_uop_i,
    input  logic                                 end_uop_i,
    input  logic                                 is_rdc_i,
    output logic [VECTOR_LANES-1:0]              wr_en_o,
    output logic [VREG_ADDR_WIDTH-1:0]           wr_addr_o,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0]   wr_data_o,
    output logic [VECTOR_LANES-1:0]              rdc_done_o,
    output logic                                 busy_o
);

    localparam int L     = VECTOR_LANES;
    localparam int W     = DATA_WIDTH;
    localparam int A     = VREG_ADDR_WIDTH;
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [2:0] OPMVV      = 3'b010;
    localparam logic [5:0] F6_ADD     = 6'b000000;
    localparam logic [5:0] F6_SUB     = 6'b000010;
    localparam logic [5:0] F6_AND     = 6'b001001;
    localparam logic [5:0] F6_OR      = 6'b001010;
    localparam logic [5:0] F6_XOR     = 6'b001011;
    localparam logic [5:0] F6_VMUL    = 6'b100101;
    localparam logic [5:0] F6_REDSUM  = 6'b000000;
    localparam logic [5:0] F6_REDAND  = 6'b000001;
    localparam logic [5:0] F6_REDOR   = 6'b000010;
    localparam logic [5:0] F6_REDXOR  = 6'b000011;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    typedef struct packed {
        logic [L-1:0]   lane_valid;
        logic [L*W-1:0] d1;
        logic [L*W-1:0] d2;
        logic [L-1:0]   mask;
        logic [5:0]     funct6;
        logic [2:0]     funct3;
        logic [A-1:0]   dst;
        logic           head;
        logic           last;
        logic           rdc;
    } uop_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    uop_t             s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             rdc_active_q, rdc_active_d;
    logic [L-1:0]     wr_en_q, wr_en_d;
    logic [A-1:0]     wr_addr_q, wr_addr_d;
    logic [L*W-1:0]   wr_data_q, wr_data_d;
    logic [L-1:0]     rdc_done_q, rdc_done_d;

    logic             s1_is_mul;
    logic             in_is_mul;
    logic             accept;
    logic             s1_drain;
    logic [L*W-1:0]   lane_flat;
    logic [W-1:0]     fold;
    logic [W-1:0]     rdc_base;
    logic [W-1:0]     rdc_res;

    assign s1_is_mul = s1_valid_q & ~s1_q.rdc & (s1_q.funct3 == OPMVV) & (s1_q.funct6 == F6_VMUL);
    assign in_is_mul = ~is_rdc_i & (funct3_i == OPMVV) & (funct6_i == F6_VMUL);
    assign ready_o   = (state_q == ST_RUN) & ~s1_is_mul;
    assign accept    = valid_i & ready_o;
    // A vmul leaves S1 only once its countdown has expired; all else drain every cycle.
    assign s1_drain  = s1_valid_q & (~s1_is_mul | (mul_cnt_q == '0));

    // Per-lane element ALU, evaluated on the S1 operands.
    for (genvar k = 0; k < L; k++) begin : g_lane
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        assign a = s1_q.d1[k*W +: W];
        assign b = s1_q.d2[k*W +: W];
        always_comb begin
            r = '0;
            if (s1_q.funct3 != OPMVV) begin
                case (s1_q.funct6)
                    F6_ADD:  r = a + b;
                    F6_SUB:  r = b - a;
                    F6_AND:  r = a & b;
                    F6_OR:   r = a | b;
                    F6_XOR:  r = a ^ b;
                    default: r = '0;
                endcase
            end else if (s1_q.funct6 == F6_VMUL) begin
                r = a * b;
            end
        end
        assign lane_flat[k*W +: W] = r;
    end

    // Reduction: fold the active data2 lanes, then combine with seed or accumulator.
    always_comb begin
        fold = (s1_q.funct6 == F6_REDAND) ? '1 : '0;
        for (int k = 0; k < L; k++) begin
            if (s1_q.lane_valid[k]) begin
                case (s1_q.funct6)
                    F6_REDSUM: fold = fold + s1_q.d2[k*W +: W];
                    F6_REDAND: fold = fold & s1_q.d2[k*W +: W];
                    F6_REDOR:  fold = fold | s1_q.d2[k*W +: W];
                    F6_REDXOR: fold = fold ^ s1_q.d2[k*W +: W];
                    default:   fold = fold;
                endcase
            end
        end
        // A head uop always restarts from its own seed, discarding any partial.
        rdc_base = s1_q.head ? s1_q.d1[W-1:0] : acc_q;
        rdc_res  = '0;
        if (s1_q.funct3 == OPMVV) begin
            case (s1_q.funct6)
                F6_REDSUM: rdc_res = rdc_base + fold;
                F6_REDAND: rdc_res = rdc_base & fold;
                F6_REDOR:  rdc_res = rdc_base | fold;
                F6_REDXOR: rdc_res = rdc_base ^ fold;
                default:   rdc_res = '0;
            endcase
        end
    end

    // Multiply-occupancy FSM.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && in_is_mul) begin
                    state_d   = ST_MUL;
                    mul_cnt_d = MUL_LOAD;
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mul_cnt_d = mul_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline, accumulator and writeback next-state.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_d         = s1_q;
        s2_valid_d   = s1_drain;
        acc_d        = acc_q;
        rdc_active_d = rdc_active_q;
        wr_en_d      = '0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        rdc_done_d   = '0;

        if (s1_drain) begin
            s1_valid_d = 1'b0;
            wr_addr_d  = s1_q.dst;
            if (s1_q.rdc) begin
                if (s1_q.last) begin
                    wr_en_d          = {{(L-1){1'b0}}, s1_q.mask[0]};
                    wr_data_d[W-1:0] = rdc_res;
                    rdc_done_d       = '1;
                    acc_d            = '0;
                    rdc_active_d     = 1'b0;
                end else begin
                    acc_d        = rdc_res;
                    rdc_active_d = 1'b1;
                end
            end else begin
                wr_en_d   = s1_q.lane_valid & s1_q.mask;
                wr_data_d = lane_flat;
            end
        end

        // Accepting while S1 drains keeps full throughput.
        if (accept) begin
            s1_valid_d      = 1'b1;
            s1_d.lane_valid = lane_valid_i;
            s1_d.d1         = data1_i;
            s1_d.d2         = data2_i;
            s1_d.mask       = mask_i;
            s1_d.funct6     = funct6_i;
            s1_d.funct3     = funct3_i;
            s1_d.dst        = dst_i;
            s1_d.head       = head_uop_i;
            s1_d.last       = end_uop_i;
            s1_d.rdc        = is_rdc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            mul_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s2_valid_q   <= 1'b0;
            acc_q        <= '0;
            rdc_active_q <= 1'b0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rdc_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            mul_cnt_q    <= mul_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s2_valid_q   <= s2_valid_d;
            acc_q        <= acc_d;
            rdc_active_q <= rdc_active_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rdc_done_q   <= rdc_done_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign rdc_done_o = rdc_done_q;
    assign busy_o     = s1_valid_q | s2_valid_q | rdc_active_q;

endmodule
`default_nettype wire

// File: tb/tb_vex_uop_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vex_uop_sink
//  Purpose  : Self-checking bench for vex_uop_sink; expected writebacks are
//             queued at issue and compared when the sink writes back.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vex_uop_sink;

    localparam int L  = 8;
    localparam int W  = 32;
    localparam int A  = 5;
    localparam int MC = 3;
    localparam logic [2:0] OPIVV = 3'b000;
    localparam logic [2:0] OPMVV = 3'b010;

    typedef struct {
        logic [L-1:0]   en;
        logic [A-1:0]   addr;
        logic [L*W-1:0] data;
        logic [L-1:0]   rdc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_i;
    logic           ready_o;
    logic [L-1:0]   lane_valid_i;
    logic [L*W-1:0] data1_i;
    logic [L*W-1:0] data2_i;
    logic [L-1:0]   mask_i;
    logic [5:0]     funct6_i;
    logic [2:0]     funct3_i;
    logic [A-1:0]   dst_i;
    logic           head_uop_i;
    logic           end_uop_i;
    logic           is_rdc_i;
    logic [L-1:0]   wr_en_o;
    logic [A-1:0]   wr_addr_o;
    logic [L*W-1:0] wr_data_o;
    logic [L-1:0]   rdc_done_o;
    logic           busy_o;

    exp_t sb[$];
    int   wb_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc;

    vex_uop_sink #(
        .VECTOR_LANES   (L),
        .DATA_WIDTH     (W),
        .VREG_ADDR_WIDTH(A),
        .MUL_CYCLES     (MC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .lane_valid_i(lane_valid_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .mask_i      (mask_i),
        .funct6_i    (funct6_i),
        .funct3_i    (funct3_i),
        .dst_i       (dst_i),
        .head_uop_i  (head_uop_i),
        .end_uop_i   (end_uop_i),
        .is_rdc_i    (is_rdc_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .rdc_done_o  (rdc_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: any writeback or reduction-done must match the queue head.
    always @(negedge clk) begin
        if (wr_en_o != '0 || rdc_done_o != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {wr_en_o, rdc_done_o}, '0);
            end else begin
                exp_t e;
                logic [L*W-1:0] m;
                e = sb.pop_front();
                wb_cyc.push_back(cyc);
                m = '0;
                for (int k = 0; k < L; k++) if (e.en[k]) m[k*W +: W] = '1;
                chk("wr_en", wr_en_o, e.en);
                chk("wr_addr", wr_addr_o, e.addr);
                chk("wr_data", wr_data_o & m, e.data & m);
                chk("rdc_done", rdc_done_o, e.rdc);
            end
        end
    end

    task automatic send(input logic [L-1:0] lv, input logic [L*W-1:0] d1, input logic [L*W-1:0] d2,
                        input logic [L-1:0] mk, input logic [5:0] f6, input logic [2:0] f3,
                        input logic [A-1:0] dst, input logic hd, input logic en, input logic rd,
                        input bit push, input exp_t e, output int waited);
        int n;
        @(negedge clk);
        valid_i = 1'b1; lane_valid_i = lv; data1_i = d1; data2_i = d2; mask_i = mk;
        funct6_i = f6; funct3_i = f3; dst_i = dst; head_uop_i = hd; end_uop_i = en; is_rdc_i = rd;
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 1'b1, 1'b0);
        if (push) sb.push_back(e);
        waited = n;
        @(posedge clk);
        #1 valid_i = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (n < 50), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wr_en", wr_en_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
    endtask

    function automatic exp_t mk_exp(input logic [L-1:0] en, input logic [A-1:0] a,
                                    input logic [L*W-1:0] d, input logic [L-1:0] r);
        exp_t e;
        e.en = en; e.addr = a; e.data = d; e.rdc = r;
        return e;
    endfunction

    initial begin
        logic [L*W-1:0] d1, d2, ex, ex2, ex3;
        int w0, w1, w2, lo;
        exp_t none;
        none = mk_exp('0, '0, '0, '0);

        rst = 1'b1; valid_i = 1'b0; lane_valid_i = '0; data1_i = '0; data2_i = '0; mask_i = '0;
        funct6_i = '0; funct3_i = '0; dst_i = '0; head_uop_i = 1'b0; end_uop_i = 1'b0; is_rdc_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_wr_en", wr_en_o, '0);
        chk("reset_wr_data", wr_data_o, '0);
        chk("reset_wr_addr", wr_addr_o, '0);
        chk("reset_rdc_done", rdc_done_o, '0);
        chk("reset_busy", busy_o, 1'b0);
        rst = 1'b0;

        // Add on half the lanes: data[i] = i + 10*i.
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = W'(i); d2[i*W +: W] = W'(10 * i); ex[i*W +: W] = W'(11 * i);
        end
        wb_cyc.delete();
        send(8'h0F, d1, d2, 8'hFF, 6'b000000, OPIVV, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'h0F, 5'd3, ex, '0), w0);
        wait_drain();
        chk("add_latency", (wb_cyc.size() == 1) ? wb_cyc[0] - acc_cyc : -1, 1);

        // Back-to-back add / xor / sub.
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = W'(i); d2[i*W +: W] = 1;
            ex[i*W +: W] = W'(i + 1); ex2[i*W +: W] = W'(i ^ 1); ex3[i*W +: W] = W'(1 - i);
        end
        wb_cyc.delete();
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPIVV, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'hFF, 5'd4, ex, '0), w0);
        send(8'hFF, d1, d2, 8'hFF, 6'b001011, OPIVV, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'hFF, 5'd5, ex2, '0), w1);
        send(8'hFF, d1, d2, 8'hFF, 6'b000010, OPIVV, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'hFF, 5'd6, ex3, '0), w2);
        chk("b2b_ready0", w0, 0);
        chk("b2b_ready1", w1, 0);
        chk("b2b_ready2", w2, 0);
        wait_drain();
        chk("b2b_wb_count", wb_cyc.size(), 3);
        if (wb_cyc.size() == 3) begin
            chk("b2b_consec1", wb_cyc[1] - wb_cyc[0], 1);
            chk("b2b_consec2", wb_cyc[2] - wb_cyc[1], 1);
        end

        // vmul 7*6; the sink stalls while the multiply occupies S1.
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = 7; d2[i*W +: W] = 6; ex[i*W +: W] = 42;
        end
        send(8'hFF, d1, d2, 8'hFF, 6'b100101, OPMVV, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'hFF, 5'd7, ex, '0), w0);
        lo = 0;
        @(negedge clk);
        while (!ready_o && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        chk("vmul_stall_cycles", lo, MC);
        wait_drain();
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = 32'hFFFF_FFFF; d2[i*W +: W] = 2; ex[i*W +: W] = 32'hFFFF_FFFE;
        end
        send(8'hFF, d1, d2, 8'h01, 6'b100101, OPMVV, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'h01, 5'd8, ex, '0), w0);
        wait_drain();

        // redsum over VL=12: seed 5 + 8 + 4 = 17, lanes 4..7 of uop2 inactive.
        d1 = '0; d1[W-1:0] = 5;
        for (int i = 0; i < L; i++) d2[i*W +: W] = 1;
        ex = '0; ex[W-1:0] = 17;
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPMVV, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, none, w0);
        repeat (3) @(negedge clk);
        chk("rdc_busy_between", busy_o, 1'b1);
        send(8'h0F, '0, d2, 8'hFF, 6'b000000, OPMVV, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1,
             mk_exp(8'h01, 5'd9, ex, '1), w0);
        wait_drain();

        // redand with inactive lanes holding 0: 0xFF & 0x0F.
        d1 = '0; d1[W-1:0] = 32'hFF; d2 = '0;
        for (int i = 0; i < 4; i++) d2[i*W +: W] = 32'h0F;
        ex = '0; ex[W-1:0] = 32'h0F;
        send(8'h0F, d1, d2, 8'hFF, 6'b000001, OPMVV, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1,
             mk_exp(8'h01, 5'd10, ex, '1), w0);
        wait_drain();

        // redxor: 1 ^ (1^2^4^..^128) = 0xFE.
        d1 = '0; d1[W-1:0] = 1;
        for (int i = 0; i < L; i++) d2[i*W +: W] = W'(1 << i);
        ex = '0; ex[W-1:0] = 32'hFE;
        send(8'hFF, d1, d2, 8'hFF, 6'b000011, OPMVV, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1,
             mk_exp(8'h01, 5'd11, ex, '1), w0);
        wait_drain();

        // A second head discards the partial sum: 2 + 8 = 10.
        for (int i = 0; i < L; i++) d2[i*W +: W] = 1;
        d1 = '0; d1[W-1:0] = 100;
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPMVV, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, none, w0);
        d1 = '0; d1[W-1:0] = 2;
        ex = '0; ex[W-1:0] = 10;
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPMVV, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1,
             mk_exp(8'h01, 5'd12, ex, '1), w0);
        wait_drain();

        // Write mask gating and an unsupported opcode that writes zeros.
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = W'(3 * i + 1); d2[i*W +: W] = 32'hF0F0; ex[i*W +: W] = W'((3 * i + 1) | 32'hF0F0);
        end
        send(8'hFF, d1, d2, 8'hF0, 6'b001010, OPIVV, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'hF0, 5'd13, ex, '0), w0);
        send(8'h3F, d1, d2, 8'hFF, 6'b000111, OPIVV, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1,
             mk_exp(8'h3F, 5'd14, '0, '0), w0);
        wait_drain();

        // Reset during a vmul and during a reduction: nothing is written back.
        for (int i = 0; i < L; i++) begin
            d1[i*W +: W] = 9; d2[i*W +: W] = 9;
        end
        send(8'hFF, d1, d2, 8'hFF, 6'b100101, OPMVV, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, none, w0);
        do_reset();
        repeat (5) @(negedge clk);
        chk("post_rst_mul_busy", busy_o, 1'b0);
        for (int i = 0; i < L; i++) d2[i*W +: W] = 1;
        d1 = '0; d1[W-1:0] = 50;
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPMVV, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, none, w0);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        chk("post_rst_rdc_busy", busy_o, 1'b0);
        d1 = '0; d1[W-1:0] = 1;
        ex = '0; ex[W-1:0] = 9;
        send(8'hFF, d1, d2, 8'hFF, 6'b000000, OPMVV, 5'd17, 1'b1, 1'b1, 1'b1, 1'b1,
             mk_exp(8'h01, 5'd17, ex, '1), w0);
        wait_drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
